// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and EX-side training signals of the branch predictor, plus its perf counters.
interface branch_predictor_if #(
   parameter int XLEN     = 32,
   parameter int GHR_BITS = 6,
   parameter int CNT_W    = 32
);
   logic [XLEN-1:0]     pred_pc;
   logic                pred_taken;
   logic [XLEN-1:0]     pred_target;
   logic [GHR_BITS-1:0] pred_ghr;

   logic                upd_valid;
   logic [XLEN-1:0]     upd_pc;
   logic                upd_is_br;
   logic                upd_is_jal;
   logic                upd_taken;
   logic [XLEN-1:0]     upd_target;
   logic [GHR_BITS-1:0] upd_ghr;
   logic                upd_mispredict;

   logic [CNT_W-1:0]    cnt_branches;
   logic [CNT_W-1:0]    cnt_mispredicts;

   modport master (
      output pred_pc, upd_valid, upd_pc, upd_is_br, upd_is_jal, upd_taken,
             upd_target, upd_ghr, upd_mispredict,
      input  pred_taken, pred_target, pred_ghr, cnt_branches, cnt_mispredicts
   );

   modport slave (
      input  pred_pc, upd_valid, upd_pc, upd_is_br, upd_is_jal, upd_taken,
             upd_target, upd_ghr, upd_mispredict,
      output pred_taken, pred_target, pred_ghr, cnt_branches, cnt_mispredicts
   );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus 2-bit counter pattern table (bimodal or gshare) with a
// non-speculative global history, zero-latency lookup and EX-driven training.
module branch_predictor #(
   parameter int XLEN        = 32,
   parameter int MODE        = 2,
   parameter int PHT_ENTRIES = 64,
   parameter int GHR_BITS    = 6,
   parameter int BTB_ENTRIES = 16,
   parameter int CNT_W       = 32
) (
   input logic              clk,
   input logic              rst,
   branch_predictor_if.slave bp
);
   localparam int BTB_IW = $clog2(BTB_ENTRIES);
   localparam int PHT_IW = $clog2(PHT_ENTRIES);
   localparam int TAG_W  = XLEN - BTB_IW - 2;

   logic              btb_valid  [BTB_ENTRIES];
   logic [TAG_W-1:0]  btb_tag    [BTB_ENTRIES];
   logic [XLEN-1:0]   btb_target [BTB_ENTRIES];
   logic              btb_is_jal [BTB_ENTRIES];
   logic [1:0]        pht        [PHT_ENTRIES];
   logic [GHR_BITS-1:0] ghr;
   logic [CNT_W-1:0]  cnt_br;
   logic [CNT_W-1:0]  cnt_mp;

   function automatic logic [PHT_IW-1:0] pht_index(input logic [XLEN-1:0] pc,
                                                   input logic [GHR_BITS-1:0] hist);
      if (MODE == 2) return pc[PHT_IW+1:2] ^ PHT_IW'(hist);
      else           return pc[PHT_IW+1:2];
   endfunction

   // lookup
   logic [BTB_IW-1:0] lk_bidx;
   logic [TAG_W-1:0]  lk_tag;
   logic [PHT_IW-1:0] lk_pidx;
   logic              lk_hit;
   logic              lk_taken;

   assign lk_bidx  = bp.pred_pc[BTB_IW+1:2];
   assign lk_tag   = bp.pred_pc[XLEN-1:BTB_IW+2];
   assign lk_pidx  = pht_index(bp.pred_pc, ghr);
   assign lk_hit   = btb_valid[lk_bidx] && (btb_tag[lk_bidx] == lk_tag);
   assign lk_taken = (MODE != 0) && lk_hit && (btb_is_jal[lk_bidx] || pht[lk_pidx][1]);

   assign bp.pred_taken      = lk_taken;
   assign bp.pred_target     = lk_taken ? btb_target[lk_bidx] : bp.pred_pc + XLEN'(4);
   assign bp.pred_ghr        = ghr;
   assign bp.cnt_branches    = cnt_br;
   assign bp.cnt_mispredicts = cnt_mp;

   // update
   logic                upd_ctl;
   logic                btb_we;
   logic [BTB_IW-1:0]   u_bidx;
   logic [PHT_IW-1:0]   u_pidx;
   logic [1:0]          pht_nxt;
   logic [GHR_BITS-1:0] ghr_nxt;

   assign upd_ctl = bp.upd_valid && (bp.upd_is_br || bp.upd_is_jal);
   assign btb_we  = upd_ctl && bp.upd_taken;
   assign u_bidx  = bp.upd_pc[BTB_IW+1:2];
   assign u_pidx  = pht_index(bp.upd_pc, bp.upd_ghr);

   always_comb begin
      pht_nxt = pht[u_pidx];
      if (bp.upd_taken && (pht[u_pidx] != 2'd3))
         pht_nxt = pht[u_pidx] + 2'd1;
      else if (!bp.upd_taken && (pht[u_pidx] != 2'd0))
         pht_nxt = pht[u_pidx] - 2'd1;
   end

   if (GHR_BITS == 1) begin : g_ghr_one
      assign ghr_nxt = bp.upd_taken;
   end else begin : g_ghr_shift
      assign ghr_nxt = {ghr[GHR_BITS-2:0], bp.upd_taken};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
         for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= 2'b01;
         ghr    <= '0;
         cnt_br <= '0;
         cnt_mp <= '0;
      end else begin
         if (upd_ctl) begin
            cnt_br <= cnt_br + CNT_W'(1);
            if (bp.upd_is_br) begin
               pht[u_pidx] <= pht_nxt;
               ghr         <= ghr_nxt;
            end
         end
         if (btb_we) btb_valid[u_bidx] <= 1'b1;
         if (bp.upd_valid && bp.upd_mispredict) cnt_mp <= cnt_mp + CNT_W'(1);
      end
   end

   // payload is only observable behind a valid bit, so it needs no reset
   always_ff @(posedge clk) begin
      if (btb_we) begin
         btb_tag[u_bidx]    <= bp.upd_pc[XLEN-1:BTB_IW+2];
         btb_target[u_bidx] <= bp.upd_target;
         btb_is_jal[u_bidx] <= bp.upd_is_jal;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{bp.pred_pc[1:0], bp.upd_pc[1:0], bp.upd_ghr};
endmodule

// File: tb/tb_branch_predictor.sv
// Four predictor configurations driven in lockstep and compared every cycle
// against a table-level model, plus directed scenario checks.
module tb_branch_predictor;
   localparam int G0 = 6, G1 = 3, G2 = 2, G3 = 1;
   localparam int C0 = 32, C1 = 4, C2 = 8, C3 = 32;
   localparam int unsigned MD[4] = '{2, 1, 2, 0};
   localparam int unsigned PE[4] = '{64, 16, 16, 4};
   localparam int unsigned BE[4] = '{16, 4, 8, 2};
   localparam int unsigned GB[4] = '{G0, G1, G2, G3};
   localparam int unsigned CW[4] = '{C0, C1, C2, C3};

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] pc, u_pc, u_tgt;
   logic        u_valid, u_br, u_jal, u_taken, u_mp;
   logic [31:0] u_ghr [4];

   logic        obs_tk [4];
   logic [31:0] obs_tg [4], obs_gh [4], obs_cb [4], obs_cm [4];

   int n_checks = 0;
   int n_errors = 0;

   branch_predictor_if #(.XLEN(32), .GHR_BITS(G0), .CNT_W(C0)) bif0 ();
   branch_predictor_if #(.XLEN(32), .GHR_BITS(G1), .CNT_W(C1)) bif1 ();
   branch_predictor_if #(.XLEN(32), .GHR_BITS(G2), .CNT_W(C2)) bif2 ();
   branch_predictor_if #(.XLEN(32), .GHR_BITS(G3), .CNT_W(C3)) bif3 ();

   branch_predictor #(.XLEN(32), .MODE(2), .PHT_ENTRIES(64), .GHR_BITS(G0), .BTB_ENTRIES(16), .CNT_W(C0))
      u_bp0 (.clk(clk), .rst(rst), .bp(bif0));
   branch_predictor #(.XLEN(32), .MODE(1), .PHT_ENTRIES(16), .GHR_BITS(G1), .BTB_ENTRIES(4), .CNT_W(C1))
      u_bp1 (.clk(clk), .rst(rst), .bp(bif1));
   branch_predictor #(.XLEN(32), .MODE(2), .PHT_ENTRIES(16), .GHR_BITS(G2), .BTB_ENTRIES(8), .CNT_W(C2))
      u_bp2 (.clk(clk), .rst(rst), .bp(bif2));
   branch_predictor #(.XLEN(32), .MODE(0), .PHT_ENTRIES(4), .GHR_BITS(G3), .BTB_ENTRIES(2), .CNT_W(C3))
      u_bp3 (.clk(clk), .rst(rst), .bp(bif3));

   assign bif0.pred_pc = pc; assign bif0.upd_valid = u_valid; assign bif0.upd_pc = u_pc;
   assign bif0.upd_is_br = u_br; assign bif0.upd_is_jal = u_jal; assign bif0.upd_taken = u_taken;
   assign bif0.upd_target = u_tgt; assign bif0.upd_mispredict = u_mp; assign bif0.upd_ghr = u_ghr[0][G0-1:0];
   assign bif1.pred_pc = pc; assign bif1.upd_valid = u_valid; assign bif1.upd_pc = u_pc;
   assign bif1.upd_is_br = u_br; assign bif1.upd_is_jal = u_jal; assign bif1.upd_taken = u_taken;
   assign bif1.upd_target = u_tgt; assign bif1.upd_mispredict = u_mp; assign bif1.upd_ghr = u_ghr[1][G1-1:0];
   assign bif2.pred_pc = pc; assign bif2.upd_valid = u_valid; assign bif2.upd_pc = u_pc;
   assign bif2.upd_is_br = u_br; assign bif2.upd_is_jal = u_jal; assign bif2.upd_taken = u_taken;
   assign bif2.upd_target = u_tgt; assign bif2.upd_mispredict = u_mp; assign bif2.upd_ghr = u_ghr[2][G2-1:0];
   assign bif3.pred_pc = pc; assign bif3.upd_valid = u_valid; assign bif3.upd_pc = u_pc;
   assign bif3.upd_is_br = u_br; assign bif3.upd_is_jal = u_jal; assign bif3.upd_taken = u_taken;
   assign bif3.upd_target = u_tgt; assign bif3.upd_mispredict = u_mp; assign bif3.upd_ghr = u_ghr[3][G3-1:0];

   assign obs_tk[0] = bif0.pred_taken; assign obs_tg[0] = bif0.pred_target; assign obs_gh[0] = 32'(bif0.pred_ghr);
   assign obs_cb[0] = 32'(bif0.cnt_branches); assign obs_cm[0] = 32'(bif0.cnt_mispredicts);
   assign obs_tk[1] = bif1.pred_taken; assign obs_tg[1] = bif1.pred_target; assign obs_gh[1] = 32'(bif1.pred_ghr);
   assign obs_cb[1] = 32'(bif1.cnt_branches); assign obs_cm[1] = 32'(bif1.cnt_mispredicts);
   assign obs_tk[2] = bif2.pred_taken; assign obs_tg[2] = bif2.pred_target; assign obs_gh[2] = 32'(bif2.pred_ghr);
   assign obs_cb[2] = 32'(bif2.cnt_branches); assign obs_cm[2] = 32'(bif2.cnt_mispredicts);
   assign obs_tk[3] = bif3.pred_taken; assign obs_tg[3] = bif3.pred_target; assign obs_gh[3] = 32'(bif3.pred_ghr);
   assign obs_cb[3] = 32'(bif3.cnt_branches); assign obs_cm[3] = 32'(bif3.cnt_mispredicts);

   // reference model: tables as plain arrays, BTB entries remember the whole pc
   int              m_pht [4][64];
   bit              m_bv  [4][16];
   bit              m_bj  [4][16];
   logic [31:0]     m_bpc [4][16];
   logic [31:0]     m_btg [4][16];
   int unsigned     m_ghr [4];
   longint unsigned m_cb  [4];
   longint unsigned m_cm  [4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 64; j++) m_pht[i][j] = 1;
         for (int j = 0; j < 16; j++) m_bv[i][j] = 1'b0;
         m_ghr[i] = 0;
         m_cb[i]  = 0;
         m_cm[i]  = 0;
      end
   endfunction

   function automatic void model_pred(input int i, input logic [31:0] a,
                                      output bit tk, output logic [31:0] tg);
      int unsigned bi  = (a >> 2) % BE[i];
      int unsigned pi  = (a >> 2) % PE[i];
      bit          hit = m_bv[i][bi] && ((m_bpc[i][bi] >> 2) / BE[i] == (a >> 2) / BE[i]);
      if (MD[i] == 2) pi = pi ^ m_ghr[i];
      tk = (MD[i] != 0) && hit && (m_bj[i][bi] || m_pht[i][pi] >= 2);
      tg = tk ? m_btg[i][bi] : a + 32'd4;
   endfunction

   function automatic void model_update();
      for (int i = 0; i < 4; i++) begin
         longint unsigned cmask = (64'd1 << CW[i]) - 64'd1;
         int unsigned     gmask = (1 << GB[i]) - 1;
         int unsigned     bi    = (u_pc >> 2) % BE[i];
         int unsigned     pi    = (u_pc >> 2) % PE[i];
         if (!u_valid) continue;
         if (MD[i] == 2) pi = pi ^ (u_ghr[i] & gmask);
         if (u_br || u_jal) m_cb[i] = (m_cb[i] + 1) & cmask;
         if (u_mp)          m_cm[i] = (m_cm[i] + 1) & cmask;
         if (u_br) begin
            if (u_taken) m_pht[i][pi] = (m_pht[i][pi] == 3) ? 3 : m_pht[i][pi] + 1;
            else         m_pht[i][pi] = (m_pht[i][pi] == 0) ? 0 : m_pht[i][pi] - 1;
            m_ghr[i] = ((m_ghr[i] << 1) | int'(u_taken)) & gmask;
         end
         if ((u_br || u_jal) && u_taken) begin
            m_bv[i][bi]  = 1'b1;
            m_bpc[i][bi] = u_pc;
            m_btg[i][bi] = u_tgt;
            m_bj[i][bi]  = u_jal;
         end
      end
   endfunction

   task automatic model_check();
      bit          tk;
      logic [31:0] tg;
      for (int i = 0; i < 4; i++) begin
         model_pred(i, pc, tk, tg);
         check($sformatf("u%0d_taken", i),  32'(obs_tk[i]), 32'(tk));
         check($sformatf("u%0d_target", i), obs_tg[i], tg);
         check($sformatf("u%0d_ghr", i),    obs_gh[i], m_ghr[i]);
         check($sformatf("u%0d_cnt_br", i), obs_cb[i], 32'(m_cb[i]));
         check($sformatf("u%0d_cnt_mp", i), obs_cm[i], 32'(m_cm[i]));
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      model_check();
      @(posedge clk);
      if (rst) model_update();
      #1;
   endtask

   task automatic upd(input logic [31:0] a, input logic br, input logic jal, input logic tk,
                      input logic [31:0] tgt, input logic mp);
      u_valid = 1'b1; u_pc = a; u_br = br; u_jal = jal; u_taken = tk; u_tgt = tgt; u_mp = mp;
      for (int i = 0; i < 4; i++) u_ghr[i] = m_ghr[i];
   endtask

   task automatic idle();
      u_valid = 1'b0; u_br = 1'b0; u_jal = 1'b0; u_taken = 1'b0; u_mp = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      idle();
      cyc();
      rst = 1'b1;
   endtask

   function automatic logic [31:0] rand_pc();
      logic [31:0] off = 32'(4 * $urandom_range(0, 31));
      case ($urandom_range(0, 3))
         0:       return off;
         1:       return 32'h0000_1000 + off;
         2:       return 32'hFFFF_FF80 + off;
         default: return $urandom & 32'hFFFF_FFFC;
      endcase
   endfunction

   initial begin
      bit tk;
      logic [31:0] tg;
      bit seq_bim [7] = '{1, 1, 1, 1, 0, 0, 0};

      pc = 32'h100; u_pc = 0; u_tgt = 0;
      for (int i = 0; i < 4; i++) u_ghr[i] = 0;
      idle();
      model_reset();
      #2;
      check("rst_taken",  32'(obs_tk[0]), 32'd0);
      check("rst_target", obs_tg[0], 32'h104);
      check("rst_cnt_br", obs_cb[0], 32'd0);
      check("rst_cnt_mp", obs_cm[0], 32'd0);

      // an update while reset is held must be dropped
      upd(32'h100, 1'b0, 1'b1, 1'b1, 32'h500, 1'b1);
      cyc();
      rst = 1'b1;
      idle();
      #1;
      check("post_rst_taken", 32'(obs_tk[0]), 32'd0);
      check("post_rst_cnt",   obs_cb[0], 32'd0);
      cyc();

      // jal allocate, same-cycle lookup sees the old entry
      pc = 32'h200;
      upd(32'h200, 1'b0, 1'b1, 1'b1, 32'h400, 1'b1);
      #1;
      check("same_cycle_taken",  32'(obs_tk[0]), 32'd0);
      check("same_cycle_target", obs_tg[0], 32'h204);
      cyc();
      idle();
      #1;
      check("jal_taken",        32'(obs_tk[0]), 32'd1);
      check("jal_target",       obs_tg[0], 32'h400);
      check("mode0_jal_taken",  32'(obs_tk[3]), 32'd0);
      check("mode0_jal_target", obs_tg[3], 32'h204);
      pc = 32'h204;
      #1;
      check("next_pc_taken",  32'(obs_tk[0]), 32'd0);
      check("next_pc_target", obs_tg[0], 32'h208);
      pc = 32'hFFFF_FFFC;
      #1;
      check("wrap_target", obs_tg[0], 32'h0);
      cyc();

      // asynchronous reset in the middle of a cycle
      pc = 32'h200;
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check("async_rst_taken",  32'(obs_tk[0]), 32'd0);
      check("async_rst_target", obs_tg[0], 32'h204);
      check("async_rst_cnt_br", obs_cb[0], 32'd0);
      check("async_rst_cnt_mp", obs_cm[0], 32'd0);
      cyc();
      rst = 1'b1;

      // bimodal saturation on instance 1
      pc = 32'h300;
      for (int k = 0; k < 7; k++) begin
         upd(32'h300, 1'b1, 1'b0, seq_bim[k], 32'h280, 1'b0);
         cyc();
         idle();
         #1;
         if (k == 0) begin
            check("bim_first_taken",  32'(obs_tk[1]), 32'd1);
            check("bim_first_target", obs_tg[1], 32'h280);
         end
         if (k == 4) check("bim_hyst_taken", 32'(obs_tk[1]), 32'd1);
         if (k == 6) check("bim_final_taken", 32'(obs_tk[1]), 32'd0);
      end

      // gshare learns an alternating branch on instance 2
      do_reset();
      pc = 32'h40;
      for (int k = 0; k < 12; k++) begin
         model_pred(2, 32'h40, tk, tg);
         upd(32'h40, 1'b1, 1'b0, (k % 2) == 0, 32'h80, tk != ((k % 2) == 0));
         #1;
         if (k >= 8) check("gshare_pred", 32'(obs_tk[2]), 32'((k % 2) == 0));
         cyc();
      end
      idle();
      #1;
      check("gshare_cnt_mp", obs_cm[2], 32'd2);
      check("gshare_cnt_br", obs_cb[2], 32'd12);

      // counter wrap
      do_reset();
      for (int k = 0; k < 17; k++) begin
         upd(32'h500 + 32'(4 * k), 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
         cyc();
      end
      idle();
      #1;
      check("wrap4_cnt_br", obs_cb[1], 32'd1);
      check("wrap4_cnt_mp", obs_cm[1], 32'd1);
      check("wrap8_cnt_br", obs_cb[2], 32'd17);
      check("wrap8_cnt_mp", obs_cm[2], 32'd17);

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         pc = rand_pc();
         if ($urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 3))
               0:       upd(rand_pc(), 1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
               2:       upd(rand_pc(), 1'b0, 1'b1, 1'($urandom_range(0, 3) != 0), $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
               default: upd(rand_pc(), 1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
            endcase
            if ($urandom_range(0, 1) == 1)
               for (int i = 0; i < 4; i++) u_ghr[i] = $urandom;
         end else begin
            idle();
         end
         if (rst == 1'b0) begin
            rst = 1'b1;
         end else if ($urandom_range(0, 199) == 0) begin
            #2;
            rst = 1'b0;
            model_reset();
         end
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
